// File: rtl/odometer_pkg.sv
// Shared types and constants for the odometer measurement sequencer.
// Ring indices and select encodings are fixed by the ROSC block's pin order.
package odometer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STRESS,
    ST_SETTLE,
    ST_COUNT,
    ST_STORE,
    ST_DONE
  } state_e;

  localparam logic [1:0] RING_INV  = 2'd0;
  localparam logic [1:0] RING_NAND = 2'd1;
  localparam logic [1:0] RING_NOR  = 2'd2;

  localparam logic [2:0] SEL_INV_OH  = 3'b001;
  localparam logic [2:0] SEL_NAND_OH = 3'b010;
  localparam logic [2:0] SEL_NOR_OH  = 3'b100;

  function automatic logic [2:0] ring_sel(input logic [1:0] idx);
    case (idx)
      RING_INV:  return SEL_INV_OH;
      RING_NAND: return SEL_NAND_OH;
      RING_NOR:  return SEL_NOR_OH;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/rosc_edge_counter.sv
// Synchronizes the asynchronous ring output, detects rising edges and
// counts them with saturation; a lost edge at full scale flags overflow.
module rosc_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             async_in,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic sync1, sync2, sync2_d;
  logic rise;

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= async_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (en && rise) begin
      if (&count) ovf <= 1'b1;
      else        count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/odometer_meas_sequencer.sv
// Stress/measure sequencer for the three-ring odometer ROSC block: powers and
// stresses the rings, then gates each ring's edge count over a window.
module odometer_meas_sequencer
  import odometer_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int WIN_W         = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stress_en,
  input  logic             ac_mode,
  input  logic             meas_req,
  input  logic [WIN_W-1:0] win_len,
  input  logic             rosc_out,
  output logic             en_power_rosc,
  output logic             en_rosc,
  output logic             meas_stress,
  output logic             sel_inv,
  output logic             sel_nand,
  output logic             sel_nor,
  output logic             start,
  output logic             ac_dc,
  output logic [CNT_W-1:0] cnt_inv,
  output logic [CNT_W-1:0] cnt_nand,
  output logic [CNT_W-1:0] cnt_nor,
  output logic [2:0]       ovf,
  output logic             cnt_valid,
  output logic             busy
);

  // The shared settle/window timer is WIN_W wide; SETTLE_CYCLES must fit.
  localparam logic [WIN_W-1:0] SETTLE_LOAD = WIN_W'(SETTLE_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_ONE     = WIN_W'(1);

  state_e           state, state_nx;
  logic [1:0]       idx, idx_nx;
  logic [WIN_W-1:0] tmr, tmr_nx, win_q;
  logic             accept, meas_nx;
  logic [CNT_W-1:0] ring_cnt;
  logic             ring_ovf;

  rosc_edge_counter #(.CNT_W(CNT_W)) u_edge_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (rosc_out),
    .clr      ((state == ST_SETTLE) && (tmr == '0)),
    .en       (state == ST_COUNT),
    .count    (ring_cnt),
    .ovf      (ring_ovf)
  );

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    tmr_nx   = tmr;
    accept   = 1'b0;
    case (state)
      ST_IDLE, ST_STRESS: begin
        if (meas_req) begin
          state_nx = ST_SETTLE;
          idx_nx   = RING_INV;
          tmr_nx   = SETTLE_LOAD;
          accept   = 1'b1;
        end else begin
          state_nx = stress_en ? ST_STRESS : ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (tmr == '0) begin
          state_nx = ST_COUNT;
          tmr_nx   = win_q - WIN_ONE;
        end else begin
          tmr_nx = tmr - WIN_ONE;
        end
      end
      ST_COUNT: begin
        if (tmr == '0) state_nx = ST_STORE;
        else           tmr_nx   = tmr - WIN_ONE;
      end
      ST_STORE: begin
        if (idx == RING_NOR) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_SETTLE;
          idx_nx   = idx + 2'd1;
          tmr_nx   = SETTLE_LOAD;
        end
      end
      ST_DONE:  state_nx = stress_en ? ST_STRESS : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign meas_nx = state_nx inside {ST_SETTLE, ST_COUNT, ST_STORE};

  // Outputs are decoded from the next state so they change with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      idx           <= RING_INV;
      tmr           <= '0;
      win_q         <= WIN_ONE;
      en_power_rosc <= 1'b0;
      en_rosc       <= 1'b0;
      meas_stress   <= 1'b0;
      {sel_nor, sel_nand, sel_inv} <= 3'b000;
      start         <= 1'b0;
      ac_dc         <= 1'b0;
      cnt_valid     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      tmr   <= tmr_nx;
      if (accept) win_q <= (win_len == '0) ? WIN_ONE : win_len;
      en_power_rosc <= meas_nx || (state_nx == ST_STRESS);
      en_rosc       <= meas_nx;
      meas_stress   <= meas_nx;
      {sel_nor, sel_nand, sel_inv} <= meas_nx ? ring_sel(idx_nx) : 3'b000;
      start         <= (state_nx == ST_STRESS);
      ac_dc         <= (state_nx == ST_STRESS) && ac_mode;
      cnt_valid     <= (state_nx == ST_DONE);
      busy          <= meas_nx || (state_nx == ST_DONE);
    end
  end

  // NOTE: result registers are reset so a mid-measurement reset never leaves
  // stale counts visible to software.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_inv  <= '0;
      cnt_nand <= '0;
      cnt_nor  <= '0;
      ovf      <= 3'b000;
    end else if (state == ST_STORE) begin
      case (idx)
        RING_INV:  begin cnt_inv  <= ring_cnt; ovf[0] <= ring_ovf; end
        RING_NAND: begin cnt_nand <= ring_cnt; ovf[1] <= ring_ovf; end
        RING_NOR:  begin cnt_nor  <= ring_cnt; ovf[2] <= ring_ovf; end
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_odometer_meas_sequencer.sv
// Bench for odometer_meas_sequencer: a cycle-schedule model checked every
// cycle against two instances (16-bit and 4-bit counts) plus literal checks.
module tb_odometer_meas_sequencer;

  localparam int S     = 8;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stress_en = 1'b0, ac_mode = 1'b0, meas_req = 1'b0, rosc_out = 1'b0;
  logic [15:0] win_len = '0;

  logic        pwr_a, en_a, ms_a, sinv_a, snand_a, snor_a, start_a, acdc_a, valid_a, busy_a;
  logic [15:0] ci_a, cn_a, cr_a;
  logic [2:0]  ovf_a;
  logic        pwr_b, en_b, ms_b, sinv_b, snand_b, snor_b, start_b, acdc_b, valid_b, busy_b;
  logic [3:0]  ci_b, cn_b, cr_b;
  logic [2:0]  ovf_b;

  odometer_meas_sequencer #(.CNT_W(16), .WIN_W(16), .SETTLE_CYCLES(S)) dut_a (
    .clk(clk), .rst_n(rst_n), .stress_en(stress_en), .ac_mode(ac_mode),
    .meas_req(meas_req), .win_len(win_len), .rosc_out(rosc_out),
    .en_power_rosc(pwr_a), .en_rosc(en_a), .meas_stress(ms_a),
    .sel_inv(sinv_a), .sel_nand(snand_a), .sel_nor(snor_a),
    .start(start_a), .ac_dc(acdc_a), .cnt_inv(ci_a), .cnt_nand(cn_a),
    .cnt_nor(cr_a), .ovf(ovf_a), .cnt_valid(valid_a), .busy(busy_a));

  odometer_meas_sequencer #(.CNT_W(4), .WIN_W(16), .SETTLE_CYCLES(S)) dut_b (
    .clk(clk), .rst_n(rst_n), .stress_en(stress_en), .ac_mode(ac_mode),
    .meas_req(meas_req), .win_len(win_len), .rosc_out(rosc_out),
    .en_power_rosc(pwr_b), .en_rosc(en_b), .meas_stress(ms_b),
    .sel_inv(sinv_b), .sel_nand(snand_b), .sel_nor(snor_b),
    .start(start_b), .ac_dc(acdc_b), .cnt_inv(ci_b), .cnt_nand(cn_b),
    .cnt_nor(cr_b), .ovf(ovf_b), .cnt_valid(valid_b), .busy(busy_b));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, n_pulse = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input logic [31:0] act, input int lo, input int hi);
    n_vec++;
    if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Model: a measurement accepted at cycle m_p occupies offsets 0..3L, with
  // L = S+W+1 per ring (S settle, W count, 1 store) and DONE at offset 3L.
  int mcyc = 0, m_p = 0, m_win = 1, m_r, m_d;
  bit m_act = 0, m_stress = 0, m_ac = 0;
  int m_lo[3] = '{0, 0, 0};
  int m_hi[3] = '{0, 0, 0};
  int div[3]  = '{0, 0, 0};

  function automatic int ring_len();
    return S + m_win + 1;
  endfunction

  function automatic int offset();
    return mcyc - m_p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_stress = 0; m_ac = 0;
      for (int r = 0; r < 3; r++) begin m_lo[r] = 0; m_hi[r] = 0; end
    end else begin
      mcyc++;
      if (m_act && offset() > 3 * ring_len()) begin
        m_act = 0; m_stress = stress_en; m_ac = ac_mode;
      end else if (m_act) begin
        // The cycle after a ring's store cycle shows its count range.
        if ((offset() - 1) % ring_len() == ring_len() - 1) begin
          m_r = (offset() - 1) / ring_len();
          m_d = div[m_r];
          m_lo[m_r] = (m_d == 0) ? 0 : m_win / m_d;
          m_hi[m_r] = (m_d == 0) ? 0 : (m_win + m_d - 1) / m_d;
        end
      end else if (meas_req) begin
        m_act = 1; m_p = mcyc; m_win = (win_len == 0) ? 1 : int'(win_len);
      end else begin
        m_stress = stress_en; m_ac = ac_mode;
      end
    end
  end

  function automatic int stim_div();
    if (m_act && offset() < 3 * ring_len()) return div[offset() / ring_len()];
    return 0;
  endfunction

  // Square wave of period div cycles for the ring being measured, moved off the edge.
  int s_d;
  always @(posedge clk) begin
    #3;
    s_d = stim_div();
    rosc_out = (s_d == 0) ? 1'b0 : ((mcyc % s_d) < s_d / 2);
  end

  logic        e_pwr, e_en, e_start, e_ac, e_valid, e_busy;
  logic [2:0]  e_sel;
  bit          e_dc;
  logic [31:0] c_cnt_a[3], c_cnt_b[3];
  logic [2:0]  seen_sel[3];

  task automatic compare_ctrl(input string tag, input logic pwr, en, ms, input logic [2:0] sel,
                              input logic st, acdc, valid, busy);
    check({tag, "_sel"}, sel, e_sel);
    check({tag, "_cnt_valid"}, valid, e_valid);
    check({tag, "_busy"}, busy, e_busy);
    if (!e_dc) begin
      check({tag, "_en_power_rosc"}, pwr, e_pwr);
      check({tag, "_en_rosc"}, en, e_en);
      check({tag, "_meas_stress"}, ms, e_en);
      check({tag, "_start"}, st, e_start);
      check({tag, "_ac_dc"}, acdc, e_ac);
    end
  endtask

  always @(negedge clk) begin
    e_sel = 3'b000; e_en = 0; e_valid = 0; e_busy = 0; e_dc = 0;
    e_pwr = m_stress; e_start = m_stress; e_ac = m_stress & m_ac;
    if (m_act) begin
      e_busy = 1; e_pwr = 1; e_start = 0; e_ac = 0;
      if (offset() == 3 * ring_len()) begin
        e_valid = 1; e_dc = 1;
      end else begin
        e_en = 1; e_sel = 3'b001 << (offset() / ring_len());
      end
      if (offset() < 3 * ring_len() && offset() % ring_len() == 1)
        seen_sel[offset() / ring_len()] = {snor_a, snand_a, sinv_a};
    end
    if (valid_a === 1'b1) n_pulse++;
    compare_ctrl("a", pwr_a, en_a, ms_a, {snor_a, snand_a, sinv_a}, start_a, acdc_a, valid_a, busy_a);
    compare_ctrl("b", pwr_b, en_b, ms_b, {snor_b, snand_b, sinv_b}, start_b, acdc_b, valid_b, busy_b);
    c_cnt_a = '{32'(ci_a), 32'(cn_a), 32'(cr_a)};
    c_cnt_b = '{32'(ci_b), 32'(cn_b), 32'(cr_b)};
    for (int r = 0; r < 3; r++) begin
      check_rng($sformatf("cnt_a[%0d]", r), c_cnt_a[r], m_lo[r], m_hi[r]);
      check($sformatf("ovf_a[%0d]", r), 32'(ovf_a[r]), 32'(m_lo[r] > MAX_A));
      check_rng($sformatf("cnt_b[%0d]", r), c_cnt_b[r],
                (m_lo[r] > MAX_B) ? MAX_B : m_lo[r], (m_hi[r] > MAX_B) ? MAX_B : m_hi[r]);
      if (m_lo[r] > MAX_B)       check($sformatf("ovf_b[%0d]", r), 32'(ovf_b[r]), 1);
      else if (m_hi[r] <= MAX_B) check($sformatf("ovf_b[%0d]", r), 32'(ovf_b[r]), 0);
    end
  end

  task automatic pulse_req();
    @(negedge clk); meas_req = 1'b1;
    @(negedge clk); meas_req = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i < 1000; i++) begin
      if (valid_a === 1'b1) begin lat = mcyc - m_p; break; end
      @(negedge clk);
    end
    if (lat < 0) check("cnt_valid_timeout", 0, 1);
  endtask

  int lat, p0;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cnt_inv", 32'(ci_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_en_power", 32'(pwr_a), 0);

    // AC stress entry
    stress_en = 1'b1; ac_mode = 1'b1;
    @(negedge clk);
    check("stress_en_power", 32'(pwr_a), 1);
    check("stress_start", 32'(start_a), 1);
    check("stress_ac_dc", 32'(acdc_a), 1);
    check("stress_en_rosc", 32'(en_a), 0);
    check("stress_cnt_nor", 32'(cr_a), 0);

    // Three rings at CLK/4, CLK/6, CLK/8 over a 100-cycle window
    div = '{4, 6, 8}; win_len = 16'd100;
    pulse_req();
    wait_valid(lat);
    check("latency_w100", lat, 327);
    check("cnt_inv_w100", 32'(ci_a), 25);
    check_rng("cnt_nand_w100", 32'(cn_a), 16, 17);
    check_rng("cnt_nor_w100", 32'(cr_a), 12, 13);
    check("ovf_w100", 32'(ovf_a), 0);
    check("sel_ring0", 32'(seen_sel[0]), 1);
    check("sel_ring1", 32'(seen_sel[1]), 2);
    check("sel_ring2", 32'(seen_sel[2]), 4);
    check("cnt4_inv_w100", 32'(ci_b), 15);
    check("ovf4_w100", 32'(ovf_b), 3);
    repeat (2) @(negedge clk);

    // Saturation of the 4-bit instance at CLK/2
    div = '{2, 2, 2}; win_len = 16'd64;
    pulse_req();
    wait_valid(lat);
    check("latency_w64", lat, 219);
    check("cnt4_inv_sat", 32'(ci_b), 15);
    check("ovf4_inv_sat", 32'(ovf_b[0]), 1);
    check("cnt_inv_clk2", 32'(ci_a), 32);
    repeat (2) @(negedge clk);

    // Zero window, ignored re-requests, stress dropped mid-measurement
    div = '{4, 4, 4}; win_len = 16'd0; p0 = n_pulse;
    pulse_req();
    repeat (3) begin
      @(negedge clk); meas_req = 1'b1;
      @(negedge clk); meas_req = 1'b0;
    end
    stress_en = 1'b0;
    wait_valid(lat);
    check("latency_w0", lat, 30);
    @(negedge clk);
    check("idle_after_done_power", 32'(pwr_a), 0);
    check("idle_after_done_start", 32'(start_a), 0);
    repeat (40) @(negedge clk);
    check("single_cnt_valid", n_pulse - p0, 1);

    // Reset during COUNT of ring 1 (offsets 37..56 with W=20)
    stress_en = 1'b1; win_len = 16'd20; p0 = n_pulse;
    pulse_req();
    repeat (42) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_en_power", 32'(pwr_a), 0);
    check("arst_en_rosc", 32'(en_a), 0);
    check("arst_sel", 32'({snor_a, snand_a, sinv_a}), 0);
    check("arst_busy", 32'(busy_a), 0);
    check("arst_cnt_inv", 32'(ci_a), 0);
    check("arst_cnt4_inv", 32'(ci_b), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_valid_after_reset", n_pulse - p0, 0);

    // Restart begins at the INV ring
    win_len = 16'd4;
    pulse_req();
    check("restart_sel_inv", 32'({snor_a, snand_a, sinv_a}), 1);
    wait_valid(lat);
    check("latency_w4", lat, 39);
    check("cnt_inv_w4", 32'(ci_a), 1);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/odometer_meas_sequencer.md
# odometer_meas_sequencer

- Clocked sequencer for the three-ring (INV/NAND/NOR) odometer ROSC block.
- Alternates the block between stress and measurement:
  - drives EN_POWER_ROSC, EN_ROSC, MEAS_STRESS, SEL_*, START and AC_DC;
  - measures each ring in turn by counting synchronized edges of the block's OUT over a programmable gate window;
  - presents the three counts to the fullchip register interface.
- Sits in the odometer core between the scan/config registers and the rosc_block_top instances.

## Interface

Parameters:
- CNT_W, 16: width of each edge count.
- WIN_W, 16: width of gate-window length.
- SETTLE_CYCLES, 8: cycles after ring select before counting. Legal range is 3 or more, so the synchronizer is flushed.

Ports:
- CLK, input, 1: sole clock.
- RST_N, input, 1: asynchronous, active-low reset.
- STRESS_EN, input, 1: keep rings powered and stressed when not measuring.
- AC_MODE, input, 1: selects AC stress (1) or DC stress (0); driven to AC_DC.
- MEAS_REQ, input, 1: single-cycle measurement request.
- WIN_LEN, input, WIN_W: gate window in CLK cycles; 0 is treated as 1; sampled on request acceptance.
- ROSC_OUT, input, 1: the ROSC block's OUT; asynchronous to CLK.
- EN_POWER_ROSC, output, 1: ring power enable.
- EN_ROSC, output, 1: close the selected ring into oscillation.
- MEAS_STRESS, output, 1: measurement-phase flag.
- SEL_INV, SEL_NAND, SEL_NOR, outputs, 1 each: one-hot ring select; all 0 outside measurement.
- START, output, 1: stress clock gate.
- AC_DC, output, 1: stress mode.
- CNT_INV, CNT_NAND, CNT_NOR, outputs, CNT_W each: latched counts.
- OVF, output, 3: per-ring saturation flags, ordered {NOR, NAND, INV}.
- CNT_VALID, output, 1: one-cycle pulse when all three counts are updated.
- BUSY, output, 1: high from the cycle after acceptance through DONE.

## Operation

States: IDLE, STRESS, SETTLE, COUNT, STORE, DONE. Ring index is 0=INV, 1=NAND, 2=NOR.

Outputs per state (all registered):
- IDLE: all outputs 0.
- STRESS: EN_POWER_ROSC=1, START=1, AC_DC=AC_MODE; EN_ROSC=0, MEAS_STRESS=0, SEL_*=0.
- SETTLE, COUNT, STORE: EN_POWER_ROSC=1, EN_ROSC=1, MEAS_STRESS=1, START=0, SEL one-hot per index.

Transitions:
- IDLE:
  - MEAS_REQ → SETTLE with index 0;
  - else STRESS_EN → STRESS.
- STRESS:
  - MEAS_REQ → SETTLE with index 0;
  - else !STRESS_EN → IDLE.
  - MEAS_REQ has priority over STRESS_EN in both IDLE and STRESS.
- SETTLE: count SETTLE_CYCLES, then → COUNT. The edge counter is cleared on entry to COUNT.
- COUNT:
  - count WIN_LEN cycles (latched value, minimum 1);
  - each synchronized rising edge of ROSC_OUT increments the counter, saturating at 2^CNT_W−1;
  - saturation sets the ring's internal overflow bit;
  - then → STORE.
- STORE:
  - write the count to CNT_<ring> and the overflow bit to OVF[index];
  - if index < 2: index+1 → SETTLE, else → DONE.
- DONE:
  - CNT_VALID=1;
  - then → STRESS if STRESS_EN, else → IDLE.

Boundary rules:
- MEAS_REQ while BUSY is ignored and not queued.
- STRESS_EN changes during measurement take effect only at DONE.
- ROSC_OUT is passed through a 2-flop synchronizer. Edge detect compares sync stage 2 with a delayed copy. Only edges seen while in COUNT are counted.
- CNT_* and OVF hold their values until that ring's next STORE. They are 0 after reset.
- Reset mid-measurement:
  - immediately forces IDLE, all outputs 0, counters and CNT_* cleared;
  - no CNT_VALID is emitted.

## Timing

- MEAS_REQ high at edge t (IDLE/STRESS): state is SETTLE and outputs change at t+1.
- Per ring: SETTLE_CYCLES + WIN_LEN + 1 (STORE) cycles.
- CNT_VALID asserts at t+1+3·(SETTLE_CYCLES+WIN_LEN+1). With defaults and WIN_LEN=100 this is t+328.
- BUSY is high from t+1 until the cycle CNT_VALID is high, inclusive.
- Edge-to-count latency is 3 cycles (two sync stages, one edge register).
- Maximum countable edge rate is CLK/2; faster inputs alias. An on-chip divider ahead of ROSC_OUT is the integrator's responsibility.

## Structure

- Package odometer_pkg holds:
  - the state enum;
  - the ring-index localparams;
  - the SEL one-hot constants (INV=3'b001, NAND=3'b010, NOR=3'b100).
- Sub-module rosc_edge_counter contains the synchronizer, edge detect and saturating CNT_W counter, with clear/enable inputs.
- The sequencer FSM and window/settle counter live in the top.

## Test plan

- Reset, then STRESS_EN=1, AC_MODE=1 → next cycle EN_POWER_ROSC=1, START=1, AC_DC=1, EN_ROSC=0, CNT_*=0.
- MEAS_REQ with WIN_LEN=100, ROSC_OUT at CLK/4, CLK/6, CLK/8 for INV/NAND/NOR → CNT=25/16–17/12–13 (±1 per ring), OVF=0, CNT_VALID at t+328, SEL sequence 001,010,100.
- CNT_W=4, WIN_LEN=64, ROSC_OUT at CLK/2 → CNT_INV=15, OVF[0]=1.
- WIN_LEN=0 → treated as 1; CNT_VALID at t+1+3·(8+1+1)=t+31.
- MEAS_REQ repeated while BUSY → ignored, exactly one CNT_VALID. STRESS_EN=0 mid-measurement → state after DONE is IDLE.
- RST_N low during COUNT of ring 1 → all outputs 0 asynchronously, no CNT_VALID, next MEAS_REQ restarts at INV.
